sprite_blitter: RTL and testbench

- Parametrised sprite compositor feeding the frame buffer.
- Queues up to MAX_SPRITES draw requests. On a start pulse, typically at the start of vertical blanking, it streams each queued sprite frame out of the spritesheet ROM at one pixel per cycle.
- Writes opaque pixels into the frame-buffer write port and clips them to screen bounds.
- Sits between game logic (request source) and the spritesheet ROM / frame-buffer BRAM, ahead of the HDMI output path.

---
 rtl/sprite_blitter_if.sv | 39 +++
 rtl/sprite_blitter.sv | 169 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Bus bundle for the sprite blitter: request queue, control, spritesheet ROM and frame-buffer ports.
// The blitter takes the slave side; game logic / memories / bench take the master side.
interface sprite_blitter_if #(
    parameter int SPRITE_FRAME_DIM = 64,
    parameter int NUM_FRAMES       = 512,
    parameter int WIDTH            = 720,
    parameter int HEIGHT           = 1280
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int AW = $clog2(NUM_FRAMES * SPRITE_FRAME_DIM * SPRITE_FRAME_DIM);
    localparam int PW = $clog2(WIDTH * HEIGHT);

    logic          req_valid;
    logic          req_ready;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic [FW-1:0] req_frame;
    logic          start;
    logic          abort;
    logic [AW-1:0] rom_addr;
    logic [24:0]   rom_data;
    logic          fb_we;
    logic [PW-1:0] fb_addr;
    logic [23:0]   fb_data;
    logic          busy;
    logic          done;

    modport master (
        output req_valid, req_x, req_y, req_frame, start, abort, rom_data,
        input  req_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_frame, start, abort, rom_data,
        output req_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite compositor: queues draw requests, streams each sprite frame from the spritesheet ROM
// at one pixel per cycle and writes opaque, on-screen pixels into the frame buffer.
module sprite_blitter #(
    parameter int SPRITE_FRAME_DIM = 64,
    parameter int NUM_FRAMES       = 512,
    parameter int WIDTH            = 720,
    parameter int HEIGHT           = 1280,
    parameter int MAX_SPRITES      = 16,
    parameter int ROM_LATENCY      = 2
) (
    input logic              clk_pixel,
    input logic              sys_rst,
    sprite_blitter_if.slave  bus
);
    localparam int DW = $clog2(SPRITE_FRAME_DIM);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int AW = $clog2(NUM_FRAMES * SPRITE_FRAME_DIM * SPRITE_FRAME_DIM);
    localparam int PW = $clog2(WIDTH * HEIGHT);
    localparam int QW = $clog2(MAX_SPRITES);
    localparam int CW = $clog2(ROM_LATENCY + 1) + 1;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] frame;
    } sprite_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    sprite_t       queue [MAX_SPRITES];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   count;
    logic          full, empty, push, pop;

    state_t        state, state_nxt;
    sprite_t       cur;
    logic [DW-1:0] px, py;
    logic [CW-1:0] drain_cnt;
    logic          last_px, issue, done_q, drain_end;

    assign full          = count == (QW+1)'(MAX_SPRITES);
    assign empty         = count == '0;
    assign push          = bus.req_valid && !full;
    assign bus.req_ready = !full;
    assign last_px       = (&px) && (&py);
    assign drain_end     = drain_cnt == CW'(ROM_LATENCY);
    assign bus.done      = done_q;

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            done_q    <= !bus.abort && ((state == IDLE && bus.start && empty) ||
                                        (state == DRAIN && drain_end));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !empty) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (last_px && empty) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    // abort suppresses the pop so the queue is retained intact
    always_comb begin
        issue    = 1'b0;
        pop      = 1'b0;
        bus.busy = 1'b0;
        case (state)
            LOAD: begin
                bus.busy = 1'b1;
                pop      = !bus.abort;
            end
            RUN: begin
                bus.busy = 1'b1;
                issue    = 1'b1;
                pop      = last_px && !empty && !bus.abort;
            end
            DRAIN:   bus.busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                queue[wr_ptr] <= '{x: bus.req_x, y: bus.req_y, frame: bus.req_frame};
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            cur <= '0;
            px  <= '0;
            py  <= '0;
        end else if (pop) begin
            cur <= queue[rd_ptr];
            px  <= '0;
            py  <= '0;
        end else if (issue) begin
            px <= px + 1'b1;
            if (&px) py <= py + 1'b1;
        end
    end

    assign bus.rom_addr = issue ? ((AW'(cur.frame) << (2 * DW)) | (AW'(py) << DW) | AW'(px)) : '0;

    // Screen target rides alongside the ROM read; one extra bit catches off-screen overflow.
    logic [ROM_LATENCY:1] vld_pipe;
    logic [XW:0]          tx_pipe [1:ROM_LATENCY];
    logic [YW:0]          ty_pipe [1:ROM_LATENCY];
    logic                 write_ok;

    always_ff @(posedge clk_pixel) begin
        if (sys_rst || bus.abort) vld_pipe <= '0;
        else begin
            vld_pipe[1] <= issue;
            for (int i = 2; i <= ROM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk_pixel) begin
        tx_pipe[1] <= (XW+1)'(cur.x) + (XW+1)'(px);
        ty_pipe[1] <= (YW+1)'(cur.y) + (YW+1)'(py);
        for (int i = 2; i <= ROM_LATENCY; i++) begin
            tx_pipe[i] <= tx_pipe[i-1];
            ty_pipe[i] <= ty_pipe[i-1];
        end
    end

    assign write_ok = vld_pipe[ROM_LATENCY] && bus.rom_data[0] && !bus.abort &&
                      tx_pipe[ROM_LATENCY] < (XW+1)'(WIDTH) &&
                      ty_pipe[ROM_LATENCY] < (YW+1)'(HEIGHT);

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
        end else begin
            bus.fb_we <= write_ok;
            if (write_ok) begin
                bus.fb_addr <= PW'(ty_pipe[ROM_LATENCY][YW-1:0]) * PW'(WIDTH) +
                               PW'(tx_pipe[ROM_LATENCY][XW-1:0]);
                bus.fb_data <= bus.rom_data[24:1];
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model with 2-cycle latency, negedge monitor that
// tallies issues/writes per pass, and hand-computed expectations checked at the end of each pass.
module tb_sprite_blitter;
    logic clk_pixel = 1'b0;
    logic sys_rst;
    always #5 clk_pixel = ~clk_pixel;

    sprite_blitter_if bif ();

    sprite_blitter dut (
        .clk_pixel (clk_pixel),
        .sys_rst   (sys_rst),
        .bus       (bif)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [23:0] pix_rgb(input int a);
        return 24'(a * 37) ^ 24'hA5C3E1;
    endfunction

    // ROM model: data for an address issued in cycle k is visible in cycle k+2
    logic        alpha_mode;
    logic [24:0] rom_q;
    always @(posedge clk_pixel) begin
        rom_q        <= {pix_rgb(int'(bif.rom_addr)), alpha_mode ? ~bif.rom_addr[0] : 1'b1};
        bif.rom_data <= rom_q;
    end

    logic mon_clr, chk_data;
    int   mx, my, mf;
    int   seq_frame [0:3];
    int   cyc, n_we, n_done, done_cyc, n_busy, n_issue, first_issue_cyc, first_issue_val;
    int   last_issue_cyc, bad_seq, first_we_cyc, first_we_addr, first_we_data;
    int   bad_data, odd_tx, bad_addr, watch_data;

    initial begin
        forever begin
            @(negedge clk_pixel);
            if (mon_clr) begin
                cyc = 0; n_we = 0; n_done = 0; done_cyc = -1; n_busy = 0; n_issue = 0;
                first_issue_cyc = -1; first_issue_val = -1; last_issue_cyc = -1; bad_seq = 0;
                first_we_cyc = -1; first_we_addr = -1; first_we_data = -1;
                bad_data = 0; odd_tx = 0; bad_addr = 0; watch_data = -1;
            end else begin
                cyc++;
                if (bif.busy) n_busy++;
                if (bif.done) begin
                    n_done++;
                    if (n_done == 1) done_cyc = cyc;
                end
                if (bif.rom_addr != 0) begin
                    if (n_issue == 0) begin
                        first_issue_cyc = cyc;
                        first_issue_val = int'(bif.rom_addr);
                    end
                    last_issue_cyc = cyc;
                    if (n_issue < 16384 &&
                        int'(bif.rom_addr) != seq_frame[n_issue / 4096] * 4096 + n_issue % 4096)
                        bad_seq++;
                    n_issue++;
                end
                if (bif.fb_we) begin
                    int a, tx, ty, px, py;
                    a  = int'(bif.fb_addr);
                    tx = a % 720;
                    ty = a / 720;
                    if (n_we == 0) begin
                        first_we_cyc  = cyc;
                        first_we_addr = a;
                        first_we_data = int'(bif.fb_data);
                    end
                    n_we++;
                    if (a >= 921600) bad_addr++;
                    if (tx % 2 != 0) odd_tx++;
                    if (a == 7240) watch_data = int'(bif.fb_data);
                    if (chk_data) begin
                        px = tx - mx;
                        py = ty - my;
                        if (px < 0 || px > 63 || py < 0 || py > 63 ||
                            bif.fb_data != pix_rgb(mf * 4096 + py * 64 + px))
                            bad_data++;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    task automatic push(input int x, input int y, input int f);
        bif.req_valid = 1'b1;
        bif.req_x     = 10'(x);
        bif.req_y     = 11'(y);
        bif.req_frame = 9'(f);
        idle(1);
        bif.req_valid = 1'b0;
    endtask

    // cycle 0 is the start cycle; on return the bench sits in cycle 1
    task automatic start_pass();
        bif.start = 1'b1;
        mon_clr   = 1'b1;
        idle(1);
        bif.start = 1'b0;
        mon_clr   = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        bif.req_valid = 1'b0; bif.req_x = '0; bif.req_y = '0; bif.req_frame = '0;
        bif.start = 1'b0; bif.abort = 1'b0;
        alpha_mode = 1'b0; chk_data = 1'b0; mon_clr = 1'b1;
        mx = 0; my = 0; mf = 0;
        seq_frame = '{0, 0, 0, 0};
        idle(3);
        sys_rst = 1'b0;
        idle(1);
        chk("rst_req_ready", bif.req_ready, 1);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_fb_we", bif.fb_we, 0);
        chk("rst_fb_addr", bif.fb_addr, 0);
        chk("rst_fb_data", bif.fb_data, 0);
        chk("rst_rom_addr", bif.rom_addr, 0);

        // single opaque sprite
        push(10, 20, 3);
        mx = 10; my = 20; mf = 3; chk_data = 1'b1; seq_frame[0] = 3;
        start_pass();
        idle(4110);
        chk("t1_issue_cyc", first_issue_cyc, 2);
        chk("t1_issue_addr", first_issue_val, 12288);
        chk("t1_we_cyc", first_we_cyc, 5);
        chk("t1_we_addr", first_we_addr, 20 * 720 + 10);
        chk("t1_we_data", first_we_data, pix_rgb(12288));
        chk("t1_writes", n_we, 4096);
        chk("t1_issues", n_issue, 4096);
        chk("t1_seq", bad_seq, 0);
        chk("t1_data", bad_data, 0);
        chk("t1_done_cyc", done_cyc, 4101);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_busy_after", bif.busy, 0);

        // alpha: odd px transparent
        alpha_mode = 1'b1;
        push(10, 20, 3);
        start_pass();
        idle(4110);
        chk("alpha_writes", n_we, 2048);
        chk("alpha_odd_tx", odd_tx, 0);
        chk("alpha_data", bad_data, 0);
        alpha_mode = 1'b0;

        // clipping at bottom-right corner
        push(700, 1250, 4);
        mx = 700; my = 1250; mf = 4; seq_frame[0] = 4;
        start_pass();
        idle(4110);
        chk("clip_writes", n_we, 600);
        chk("clip_addr_range", bad_addr, 0);
        chk("clip_data", bad_data, 0);
        chk("clip_done_cyc", done_cyc, 4101);

        // back-to-back, third sprite pushed mid-pass
        chk_data = 1'b0;
        push(0, 0, 1);
        push(32, 0, 2);
        seq_frame = '{1, 2, 7, 0};
        start_pass();
        idle(100);
        push(100, 100, 7);
        idle(12300);
        chk("b2b_issues", n_issue, 12288);
        chk("b2b_span", last_issue_cyc - first_issue_cyc + 1, 12288);
        chk("b2b_seq", bad_seq, 0);
        chk("b2b_writes", n_we, 12288);
        chk("b2b_overlap", watch_data, pix_rgb(2 * 4096 + 10 * 64 + 8));
        chk("b2b_done_cnt", n_done, 1);
        chk("b2b_done_cyc", done_cyc, 12293);

        // queue full
        for (int i = 0; i < 16; i++) push(i * 4, 0, 10 + i);
        chk("full_ready", bif.req_ready, 0);
        push(0, 0, 99);
        chk("full_ready_17", bif.req_ready, 0);
        seq_frame[0] = 10;
        start_pass();
        idle(5);
        chk("full_head", first_issue_val, 10 * 4096);
        chk("full_ready_pop", bif.req_ready, 1);
        sys_rst = 1'b1;
        idle(1);
        sys_rst = 1'b0;
        idle(1);
        chk("full_rst_busy", bif.busy, 0);

        // abort at pixel 100 of the first of two sprites
        push(0, 0, 5);
        push(0, 0, 6);
        seq_frame[0] = 5;
        start_pass();
        idle(101);
        bif.abort = 1'b1;
        idle(1);
        bif.abort = 1'b0;
        idle(10);
        chk("abort_issues", n_issue, 101);
        chk("abort_writes", n_we, 98);
        chk("abort_done", n_done, 0);
        chk("abort_busy", bif.busy, 0);
        seq_frame[0] = 6;
        start_pass();
        idle(4110);
        chk("abort_re_issues", n_issue, 4096);
        chk("abort_re_seq", bad_seq, 0);
        chk("abort_re_done_cyc", done_cyc, 4101);

        // reset mid-pass empties the queue
        push(0, 0, 5);
        push(0, 0, 6);
        seq_frame[0] = 5;
        start_pass();
        idle(101);
        sys_rst = 1'b1;
        idle(1);
        sys_rst = 1'b0;
        idle(10);
        chk("rstrun_writes", n_we, 98);
        chk("rstrun_done", n_done, 0);
        chk("rstrun_busy", bif.busy, 0);
        chk("rstrun_ready", bif.req_ready, 1);
        start_pass();
        idle(5);
        chk("empty_done_cyc", done_cyc, 1);
        chk("empty_done_cnt", n_done, 1);
        chk("empty_busy", n_busy, 0);
        chk("empty_issues", n_issue, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
